multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 42 ++++
 rtl/mc_wait_timer.sv | 35 +++
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, states and datapath select codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_J   = 6'd2;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StRwb    = 4'd8,
        StBeq    = 4'd9,
        StJump   = 4'd10
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that stall on mem_ready and are guarded by the wait timer.
    function automatic logic is_wait_state(state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled cycles and flags expiry on the WAIT_MAX-th stalled cycle.
module mc_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [7:0] LAST_CNT = 8'(WAIT_MAX - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = tick && (cnt_q == LAST_CNT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory wait timeout.
// Define MULTICYCLE_JUMP_EN to decode opcode 2 as a jump.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       insn_done,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   wait_tick;
    logic   wait_clear;
    logic   wait_expired;

    assign wait_tick  = is_wait_state(state_q) && !mem_ready;
    // Any state change restarts the count, so every wait state is entered with zero.
    assign wait_clear = (state_d != state_q);

    mc_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wait_clear),
        .tick    (wait_tick),
        .expired (wait_expired)
    );

    always_comb begin
        state_d    = state_q;
        illegal_op = 1'b0;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (wait_expired) begin
                    state_d = StIdle;
                end
            end
            StDecode: begin
                case (Opcode)
                    OP_R:         state_d = StExec;
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_BEQ:       state_d = StBeq;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:         state_d = StJump;
`endif
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                if (Opcode == OP_LW) begin
                    state_d = StMemRd;
                end else if (Opcode == OP_SW) begin
                    state_d = StMemWr;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemRd: begin
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (wait_expired) begin
                    state_d = StIdle;
                end
            end
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                end else if (wait_expired) begin
                    state_d = StIdle;
                end
            end
            StMemWb: state_d = StFetch;
            StExec:  state_d = StRwb;
            StRwb:   state_d = StFetch;
            StBeq:   state_d = StFetch;
`ifdef MULTICYCLE_JUMP_EN
            StJump:  state_d = StFetch;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode; only the FETCH strobes and the MEMWR completion follow mem_ready.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        insn_done   = 1'b0;
        unique case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            StDecode: ALUSrcB = SRCB_IMM_SHL2;
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            StMemRd: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            StMemWb: begin
                MemtoReg  = 1'b1;
                RegWrite  = 1'b1;
                insn_done = 1'b1;
            end
            StMemWr: begin
                IorD      = 1'b1;
                MemWrite  = 1'b1;
                insn_done = mem_ready;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            StRwb: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                insn_done = 1'b1;
            end
            StBeq: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                insn_done   = 1'b1;
            end
`ifdef MULTICYCLE_JUMP_EN
            StJump: begin
                PCWrite   = 1'b1;
                PCSource  = PCSRC_JUMP;
                insn_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign mem_timeout = wait_expired;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (WAIT_MAX=4); honours MULTICYCLE_JUMP_EN.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       insn_done, illegal_op, mem_timeout;
    logic [3:0] state;
    logic [18:0] outs;

    int n_checks = 0;
    int n_pass   = 0;

    // Output vector: strobes | selects | ALUSrcB ALUOp PCSource | insn_done illegal_op mem_timeout
    localparam logic [18:0] O_IDLE     = 19'b000000_0000_000000_000;
    localparam logic [18:0] O_FETCH_R  = 19'b100101_0000_010000_000;
    localparam logic [18:0] O_FETCH_W  = 19'b000100_0000_010000_000;
    localparam logic [18:0] O_FETCH_TO = 19'b000100_0000_010000_001;
    localparam logic [18:0] O_DEC      = 19'b000000_0000_110000_000;
    localparam logic [18:0] O_DEC_ILL  = 19'b000000_0000_110000_010;
    localparam logic [18:0] O_MEMADR   = 19'b000000_0001_100000_000;
    localparam logic [18:0] O_MEMRD    = 19'b001100_0000_000000_000;
    localparam logic [18:0] O_MEMRD_TO = 19'b001100_0000_000000_001;
    localparam logic [18:0] O_MEMWB    = 19'b000000_1010_000000_100;
    localparam logic [18:0] O_MEMWR_W  = 19'b001010_0000_000000_000;
    localparam logic [18:0] O_MEMWR_D  = 19'b001010_0000_000000_100;
    localparam logic [18:0] O_EXEC     = 19'b000000_0001_001000_000;
    localparam logic [18:0] O_RWB      = 19'b000000_0110_000000_100;
    localparam logic [18:0] O_BEQ      = 19'b010000_0001_000101_100;
    localparam logic [18:0] O_JUMP     = 19'b100000_0000_000010_100;

    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA,
                   ALUSrcB, ALUOp, PCSource,
                   insn_done, illegal_op, mem_timeout};

    multicycle_control #(
        .WAIT_MAX (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Opcode      (Opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .insn_done   (insn_done),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .state       (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Leaves the bench at a falling edge with reset just released (state IDLE).
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (state !== 4'd0) $display("FAIL reset_state: got %0d want 0", state);
        else n_pass++;
        n_checks++;
        if (outs !== O_IDLE) $display("FAIL reset_outs: got %b want %b", outs, O_IDLE);
        else n_pass++;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (state !== 4'd0 || outs !== O_IDLE)
            $display("FAIL reset_held: got state %0d outs %b want 0 / %b", state, outs, O_IDLE);
        else n_pass++;
    endtask

    task automatic test_rtype();
        logic [3:0]  st [6] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
        logic [18:0] ou [6] = '{O_IDLE, O_FETCH_R, O_DEC, O_EXEC, O_RWB, O_FETCH_R};
        do_reset();
        mem_ready = 1'b1;
        Opcode    = 6'd0;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (state !== st[i]) $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, st[i]);
            else n_pass++;
            n_checks++;
            if (outs !== ou[i]) $display("FAIL rtype_outs[%0d]: got %b want %b", i, outs, ou[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    // Three stalled MEMRD cycles, ready on the 4th (same cycle as the timeout boundary).
    task automatic test_lw_wait();
        logic [3:0]  st [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
        logic [18:0] ou [10] = '{O_IDLE, O_FETCH_R, O_DEC, O_MEMADR, O_MEMRD, O_MEMRD,
                                 O_MEMRD, O_MEMRD, O_MEMWB, O_FETCH_R};
        logic        mr [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [5:0]  op [10] = '{6'd63, 6'd63, 6'd35, 6'd35, 6'd63, 6'd63, 6'd63, 6'd63,
                                 6'd63, 6'd63};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            mem_ready = mr[i];
            Opcode    = op[i];
            #1;
            n_checks++;
            if (state !== st[i]) $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, st[i]);
            else n_pass++;
            n_checks++;
            if (outs !== ou[i]) $display("FAIL lw_outs[%0d]: got %b want %b", i, outs, ou[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_sw();
        logic [3:0]  st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd1};
        logic [18:0] ou [6] = '{O_IDLE, O_FETCH_R, O_DEC, O_MEMADR, O_MEMWR_D, O_FETCH_R};
        do_reset();
        mem_ready = 1'b1;
        Opcode    = 6'd43;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (state !== st[i]) $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, st[i]);
            else n_pass++;
            n_checks++;
            if (outs !== ou[i]) $display("FAIL sw_outs[%0d]: got %b want %b", i, outs, ou[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_illegal_jump();
`ifdef MULTICYCLE_JUMP_EN
        logic [3:0]  st [7] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd10, 4'd1};
        logic [18:0] ou [7] = '{O_IDLE, O_FETCH_R, O_DEC_ILL, O_FETCH_R, O_DEC, O_JUMP, O_FETCH_R};
`else
        logic [3:0]  st [7] = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
        logic [18:0] ou [7] = '{O_IDLE, O_FETCH_R, O_DEC_ILL, O_FETCH_R, O_DEC_ILL, O_FETCH_R,
                                O_DEC_ILL};
`endif
        logic [5:0]  op [7] = '{6'd63, 6'd63, 6'd63, 6'd63, 6'd2, 6'd2, 6'd2};
        do_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            Opcode = op[i];
            #1;
            n_checks++;
            if (state !== st[i]) $display("FAIL illj_state[%0d]: got %0d want %0d", i, state, st[i]);
            else n_pass++;
            n_checks++;
            if (outs !== ou[i]) $display("FAIL illj_outs[%0d]: got %b want %b", i, outs, ou[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    // SW with one stalled write cycle, then BEQ, then R-type, no gaps.
    task automatic test_back_to_back();
        logic [3:0]  st [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd1, 4'd2, 4'd9, 4'd1,
                                 4'd2, 4'd7, 4'd8, 4'd1};
        logic [18:0] ou [14] = '{O_IDLE, O_FETCH_R, O_DEC, O_MEMADR, O_MEMWR_W, O_MEMWR_D,
                                 O_FETCH_R, O_DEC, O_BEQ, O_FETCH_R, O_DEC, O_EXEC, O_RWB,
                                 O_FETCH_R};
        logic        mr [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1};
        logic [5:0]  op [14] = '{6'd43, 6'd43, 6'd43, 6'd43, 6'd4, 6'd4, 6'd4, 6'd4, 6'd4,
                                 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            mem_ready = mr[i];
            Opcode    = op[i];
            #1;
            n_checks++;
            if (state !== st[i]) $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state, st[i]);
            else n_pass++;
            n_checks++;
            if (outs !== ou[i]) $display("FAIL b2b_outs[%0d]: got %b want %b", i, outs, ou[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    // FETCH timeout, recovery, then MEMRD timeout.
    task automatic test_timeout();
        logic [3:0]  st [16] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3,
                                 4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd1};
        logic [18:0] ou [16] = '{O_IDLE, O_FETCH_W, O_FETCH_W, O_FETCH_W, O_FETCH_TO, O_IDLE,
                                 O_FETCH_W, O_FETCH_R, O_DEC, O_MEMADR, O_MEMRD, O_MEMRD,
                                 O_MEMRD, O_MEMRD_TO, O_IDLE, O_FETCH_W};
        logic        mr [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        Opcode = 6'd35;
        for (int i = 0; i < 16; i++) begin
            mem_ready = mr[i];
            #1;
            n_checks++;
            if (state !== st[i]) $display("FAIL tmo_state[%0d]: got %0d want %0d", i, state, st[i]);
            else n_pass++;
            n_checks++;
            if (outs !== ou[i]) $display("FAIL tmo_outs[%0d]: got %b want %b", i, outs, ou[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic       mr [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        Opcode = 6'd35;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #1;
            n_checks++;
            if (state !== st[i]) $display("FAIL rmid_state[%0d]: got %0d want %0d", i, state, st[i]);
            else n_pass++;
            if (i < 4) @(negedge clk);
        end
        // Now mid-MEMRD, well away from any clock edge.
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'd0) $display("FAIL rmid_async_state: got %0d want 0", state);
        else n_pass++;
        n_checks++;
        if (outs !== O_IDLE) $display("FAIL rmid_async_outs: got %b want %b", outs, O_IDLE);
        else n_pass++;
        @(negedge clk);
        mem_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        n_checks++;
        if (state !== 4'd0) $display("FAIL rmid_release_state: got %0d want 0", state);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (state !== 4'd1) $display("FAIL rmid_first_edge: got %0d want 1", state);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_illegal_jump();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
